// File: rtl/morphle_cfg_pkg.sv
// Shared definitions for the yblock configuration loader and the cell code.
//   cfg_state_e : loader / strobe sequencer states
//   cnt_width() : counter width for a given terminal count (minimum 1 bit)
//   Vempty/V0/V1: cell value encodings shared with the cell model
package morphle_cfg_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_WAIT,
        S_SETUP,
        S_PULSE,
        S_HOLD
    } cfg_state_e;

    localparam logic [1:0] Vempty = 2'd0;
    localparam logic [1:0] V0     = 2'd1;
    localparam logic [1:0] V1     = 2'd2;

    // Bits needed to count 0 .. n-1, never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/yblock_cfgload_if.sv
// Configuration word stream (valid/ready).
//   in_data  : configuration word, bit x feeds column x
//   in_valid : source has a word
//   in_ready : loader accepts the word this cycle
// master = configuration source, slave = loader.
interface yblock_cfgload_if #(
    parameter int unsigned BLOCKWIDTH = 8
) ();

    logic [BLOCKWIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);

endinterface

// File: rtl/yblock_cfgload_strobe_gen.sv
// Three-phase confclk sequencer (SETUP -> PULSE -> HOLD) for one word.
//   clk, reset : clock, synchronous active-high reset
//   go         : word transfer this cycle; latches word and starts a sequence
//   word       : configuration word to present on cbit
//   confclk    : registered strobe, high only in the PULSE cycle
//   cbit       : registered word, stable from SETUP through HOLD, kept afterwards
//   last_phase : high during the HOLD cycle
module cfg_strobe_gen
    import morphle_cfg_pkg::*;
#(
    parameter int unsigned BLOCKWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  go,
    input  logic [BLOCKWIDTH-1:0] word,
    output logic                  confclk,
    output logic [BLOCKWIDTH-1:0] cbit,
    output logic                  last_phase
);

    cfg_state_e            r_phase;
    logic                  r_confclk;
    logic [BLOCKWIDTH-1:0] r_cbit;
    logic                  r_last_phase;

    // Phase sequencer; go is only honoured between sequences.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_phase      <= S_IDLE;
            r_confclk    <= 1'b0;
            r_cbit       <= '0;
            r_last_phase <= 1'b0;
        end else begin
            r_confclk    <= 1'b0;
            r_last_phase <= 1'b0;
            case (r_phase)
                S_IDLE: begin
                    if (go) begin
                        r_phase <= S_SETUP;
                        r_cbit  <= word;
                    end
                end
                S_SETUP: begin
                    r_phase   <= S_PULSE;
                    r_confclk <= 1'b1;
                end
                S_PULSE: begin
                    r_phase      <= S_HOLD;
                    r_last_phase <= 1'b1;
                end
                S_HOLD: begin
                    r_phase <= S_IDLE;
                end
                default: begin
                    r_phase <= S_IDLE;
                end
            endcase
        end
    end

    assign confclk    = r_confclk;
    assign cbit       = r_cbit;
    assign last_phase = r_last_phase;

endmodule

// File: rtl/yblock_cfgload.sv
// Configuration loader for one yblock: clears the array, then shifts SHIFTS
// row-wide words into the column chains, one confclk strobe per word.
//   clk, reset   : clock, synchronous active-high reset (array held in reset)
//   start        : request a full load (honoured in IDLE only)
//   busy         : load in progress
//   done         : one-cycle pulse after the last strobe's hold cycle
//   cfg_in       : word stream, slave side (in_data/in_valid/in_ready)
//   blk_reset    : yblock reset, high during the clear phase
//   blk_confclk  : yblock configuration clock strobe
//   blk_cbitin   : yblock column inputs
//   blk_cbitout  : yblock column outputs (readback only)
//   rb_data      : readback word      (YBLOCK_CFG_READBACK_EN only)
//   rb_valid     : readback strobe    (YBLOCK_CFG_READBACK_EN only)
// Optional feature macro: YBLOCK_CFG_READBACK_EN.
module yblock_cfgload
    import morphle_cfg_pkg::*;
#(
    parameter int unsigned BLOCKWIDTH = 8,
    parameter int unsigned SHIFTS     = 16,
    parameter int unsigned CLRCYCLES  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    yblock_cfgload_if.slave       cfg_in,
    output logic                  blk_reset,
    output logic                  blk_confclk,
    output logic [BLOCKWIDTH-1:0] blk_cbitin,
    input  logic [BLOCKWIDTH-1:0] blk_cbitout
`ifdef YBLOCK_CFG_READBACK_EN
    ,
    output logic [BLOCKWIDTH-1:0] rb_data,
    output logic                  rb_valid
`endif
);

    localparam int unsigned SHIFT_W = cnt_width(SHIFTS);
    localparam int unsigned CLR_W   = cnt_width(CLRCYCLES);

    // S_SETUP here stands for "strobe sequence in flight"; the sub-module
    // owns the individual SETUP/PULSE/HOLD phases.
    cfg_state_e          r_state;
    logic [CLR_W-1:0]    r_clr_cnt;
    logic [SHIFT_W-1:0]  r_shift_cnt;
    logic                r_busy;
    logic                r_done;
    logic                r_in_ready;
    logic                r_blk_reset;

    logic                w_go;
    logic                w_last_phase;

    // in_ready is high exactly in WAIT, so this is the stream handshake.
    assign w_go = r_in_ready && cfg_in.in_valid;

    // Load controller: clear phase, word wait, strobe tracking, counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_clr_cnt   <= '0;
            r_shift_cnt <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_blk_reset <= 1'b1;
        end else begin
            r_done      <= 1'b0;
            r_blk_reset <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_CLEAR;
                        r_clr_cnt   <= CLR_W'(CLRCYCLES - 1);
                        r_shift_cnt <= '0;
                        r_busy      <= 1'b1;
                        r_blk_reset <= 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_clr_cnt == '0) begin
                        r_state    <= S_WAIT;
                        r_in_ready <= 1'b1;
                    end else begin
                        r_clr_cnt   <= r_clr_cnt - 1'b1;
                        r_blk_reset <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (w_go) begin
                        r_state    <= S_SETUP;
                        r_in_ready <= 1'b0;
                    end
                end
                S_SETUP: begin
                    if (w_last_phase) begin
                        // Last word: stop without advancing so the counter never wraps.
                        if (r_shift_cnt == SHIFT_W'(SHIFTS - 1)) begin
                            r_state <= S_IDLE;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_shift_cnt <= r_shift_cnt + 1'b1;
                            r_state     <= S_WAIT;
                            r_in_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    cfg_strobe_gen #(
        .BLOCKWIDTH (BLOCKWIDTH)
    ) u_strobe (
        .clk        (clk),
        .reset      (reset),
        .go         (w_go),
        .word       (cfg_in.in_data),
        .confclk    (blk_confclk),
        .cbit       (blk_cbitin),
        .last_phase (w_last_phase)
    );

`ifdef YBLOCK_CFG_READBACK_EN
    logic [BLOCKWIDTH-1:0] r_rb_data;
    logic                  r_rb_valid;

    // Capture the bits pushed out of the column bottoms during each HOLD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rb_data  <= '0;
            r_rb_valid <= 1'b0;
        end else begin
            r_rb_valid <= 1'b0;
            if (r_state == S_SETUP && w_last_phase) begin
                r_rb_data  <= blk_cbitout;
                r_rb_valid <= 1'b1;
            end
        end
    end

    assign rb_data  = r_rb_data;
    assign rb_valid = r_rb_valid;
`else
    logic w_unused_cbitout;
    assign w_unused_cbitout = ^blk_cbitout;
`endif

    assign busy            = r_busy;
    assign done            = r_done;
    assign blk_reset       = r_blk_reset;
    assign cfg_in.in_ready = r_in_ready;

endmodule

// File: tb/tb_yblock_cfgload.sv
module tb_yblock_cfgload;

    localparam int unsigned BW = 8;
    localparam int unsigned SH = 16;
    localparam int unsigned CC = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          busy;
    logic          done;
    logic          blk_reset;
    logic          blk_confclk;
    logic [BW-1:0] blk_cbitin;
    logic [BW-1:0] blk_cbitout;
`ifdef YBLOCK_CFG_READBACK_EN
    logic [BW-1:0] rb_data;
    logic          rb_valid;
`endif

    yblock_cfgload_if #(.BLOCKWIDTH(BW)) cfg_if ();

    yblock_cfgload #(
        .BLOCKWIDTH (BW),
        .SHIFTS     (SH),
        .CLRCYCLES  (CC)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .cfg_in      (cfg_if),
        .blk_reset   (blk_reset),
        .blk_confclk (blk_confclk),
        .blk_cbitin  (blk_cbitin),
        .blk_cbitout (blk_cbitout)
`ifdef YBLOCK_CFG_READBACK_EN
        ,
        .rb_data     (rb_data),
        .rb_valid    (rb_valid)
`endif
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: load progress as elapsed cycles since start plus the
    // position (0 = none, 1..3) inside the current word's 3-cycle strobe.
    bit          chk_en    = 1'b0;
    bit          m_active  = 1'b0;
    int          m_t       = 0;
    int          m_k       = 0;
    int          m_words   = 0;
    bit          m_done    = 1'b0;
    bit          m_rst_hold = 1'b1;
    logic [BW-1:0] m_cbit  = '0;
    bit          m_rbv     = 1'b0;
    logic [BW-1:0] m_rbd   = '0;

    function automatic bit m_ready();
        return m_active && (m_t > int'(CC)) && (m_k == 0);
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_active   = 1'b0;
            m_k        = 0;
            m_done     = 1'b0;
            m_rst_hold = 1'b1;
            m_cbit     = '0;
            m_rbv      = 1'b0;
            m_rbd      = '0;
            chk_en     = 1'b1;
        end else begin
            bit rdy;
            rdy        = m_ready();
            m_done     = 1'b0;
            m_rst_hold = 1'b0;
            m_rbv      = 1'b0;
            if (!m_active) begin
                if (start) begin
                    m_active = 1'b1;
                    m_t      = 1;
                    m_words  = 0;
                    m_k      = 0;
                end
            end else begin
                m_t++;
                if (m_k == 3) begin
                    m_words++;
                    m_k   = 0;
                    m_rbv = 1'b1;
                    m_rbd = blk_cbitout;
                    if (m_words == int'(SH)) begin
                        m_active = 1'b0;
                        m_done   = 1'b1;
                    end
                end else if (m_k > 0) begin
                    m_k++;
                end else if (rdy && cfg_if.in_valid) begin
                    m_k    = 1;
                    m_cbit = cfg_if.in_data;
                end
            end
        end
    end

    // Event counters used by the directed checks.
    int n_clk  = 0;
    int n_done = 0;
    int n_rst  = 0;
    int n_rbv  = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",        32'(busy),           32'(m_active));
            chk("done",        32'(done),           32'(m_done));
            chk("in_ready",    32'(cfg_if.in_ready), 32'(m_ready()));
            chk("blk_reset",   32'(blk_reset),      32'(m_rst_hold || (m_active && m_t <= int'(CC))));
            chk("blk_confclk", 32'(blk_confclk),    32'(m_k == 2));
            chk("blk_cbitin",  32'(blk_cbitin),     32'(m_cbit));
`ifdef YBLOCK_CFG_READBACK_EN
            chk("rb_valid",    32'(rb_valid),       32'(m_rbv));
            chk("rb_data",     32'(rb_data),        32'(m_rbd));
            if (rb_valid) n_rbv++;
`endif
            if (blk_confclk) n_clk++;
            if (done)        n_done++;
            if (blk_reset)   n_rst++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One load with in_valid held high except for an optional gap in WAIT
    // before word gap_word, an optional stray start during word ign_word,
    // and an optional abort once abort_at strobes have been seen.
    task automatic run_load(input int gap_word, input int gap_len, input int ign_word,
                            input int abort_at, output int cyc);
        int  word;
        int  gap_left;
        bit  ign_fired;
        bit  hs;
        n_clk = 0; n_done = 0; n_rst = 0; n_rbv = 0;
        word = 1; gap_left = gap_len; ign_fired = 1'b0;
        cfg_if.in_data  = BW'(word);
        cfg_if.in_valid = 1'b1;
        start = 1'b1;
        step();
        cyc = 1;
        while (!done && cyc < 1000) begin
            start = 1'b0;
            if (abort_at != 0 && n_clk == abort_at) break;
            if (ign_word != 0 && word == ign_word && !ign_fired) begin
                start     = 1'b1;
                ign_fired = 1'b1;
            end
            if (gap_word != 0 && word == gap_word && cfg_if.in_ready && gap_left > 0) begin
                cfg_if.in_valid = 1'b0;
                gap_left--;
                chk("gap_confclk", 32'(blk_confclk), 32'd0);
            end else begin
                cfg_if.in_valid = 1'b1;
            end
            hs = cfg_if.in_valid && cfg_if.in_ready;
            step();
            cyc++;
            if (hs) begin
                word++;
                cfg_if.in_data = BW'(word);
            end
        end
        start = 1'b0;
        if (abort_at == 0) chk("load_finished", 32'(done), 32'd1);
        cfg_if.in_valid = 1'b0;
        step();
    endtask

    int cyc;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cfg_if.in_valid = 1'b0;
        cfg_if.in_data  = '0;
        blk_cbitout     = '0;
        step(); step();
        chk("reset_blk_reset", 32'(blk_reset), 32'd1);
        chk("reset_busy",      32'(busy),      32'd0);
        reset = 1'b0;
        step(); step();

        // Basic load: 1 + 4 + 64 cycles, 16 strobes, 4 clear cycles.
        run_load(0, 0, 0, 0, cyc);
        chk("basic_len",     32'(cyc),    32'd69);
        chk("basic_strobes", 32'(n_clk),  32'd16);
        chk("basic_done",    32'(n_done), 32'd1);
        chk("clear_len",     32'(n_rst),  32'd4);
`ifdef YBLOCK_CFG_READBACK_EN
        chk("rb_count",      32'(n_rbv),  32'd16);
`endif
        step();

        // Backpressure: 5 idle WAIT cycles before word 3.
        run_load(3, 5, 0, 0, cyc);
        chk("bp_len",     32'(cyc),   32'd74);
        chk("bp_strobes", 32'(n_clk), 32'd16);
        step();

        // Stray start during word 7 must not restart the load.
        run_load(0, 0, 7, 0, cyc);
        chk("ign_len",     32'(cyc),    32'd69);
        chk("ign_strobes", 32'(n_clk),  32'd16);
        chk("ign_done",    32'(n_done), 32'd1);
        step();

        // Abort after strobe 9.
        run_load(0, 0, 0, 9, cyc);
        reset = 1'b1;
        step();
        chk("abort_blk_reset", 32'(blk_reset),   32'd1);
        chk("abort_confclk",   32'(blk_confclk), 32'd0);
        chk("abort_busy",      32'(busy),        32'd0);
        reset = 1'b0;
        for (int i = 0; i < 100; i++) step();
        chk("abort_no_done", 32'(n_done), 32'd0);

        // Randomized traffic against the model.
        for (int c = 0; c < 4000; c++) begin
            reset           = ($urandom_range(0, 499) == 0);
            start           = ($urandom_range(0, 29) == 0);
            cfg_if.in_valid = ($urandom_range(0, 3) != 0);
            cfg_if.in_data  = BW'($urandom);
            blk_cbitout     = BW'($urandom);
            step();
        end
        reset = 1'b0;
        start = 1'b0;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
